// File: rtl/harvard_result_scanner.sv
// Data-port shim: forwards CPU traffic, then scans result words after halt.
// Optional first-mismatch capture ports under RESULT_SCAN_CAPTURE_EN.
module harvard_result_scanner #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0480,
  parameter int unsigned WORD_COUNT = 30,
  parameter logic [31:0] EXP_INIT   = 32'hCBA8_7AE0,
  parameter logic [31:0] EXP_STEP   = 32'hDCBA_2345,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_active,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] ram_data_address,
  output logic        ram_data_read,
  output logic        ram_data_write,
  output logic [31:0] ram_data_writedata,
  input  logic [31:0] ram_data_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
`ifdef RESULT_SCAN_CAPTURE_EN
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic        fail_valid,
`endif
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    WAIT_ACT, RUN, SCAN, DONE
  } state_t;

  localparam logic [31:0] MAXC = 32'(MAX_CYCLES);
  localparam logic [31:0] LAST =
    32'(WORD_COUNT > 0 ? WORD_COUNT - 1 : 0);

  state_t      state, state_n;
  logic [31:0] idx, exp_val, cyc;
  logic [15:0] err_q, err_n;
  logic        pass_q, tout_q;
  logic        mism, tout_hit;

  assign mism  = ram_data_readdata != exp_val;
  assign err_n = (mism && err_q != 16'hFFFF)
               ? err_q + 16'd1 : err_q;

  assign cpu_data_readdata = ram_data_readdata;
  assign busy      = state == SCAN;
  assign done      = state == DONE;
  assign pass      = pass_q;
  assign timeout   = tout_q;
  assign err_count = err_q;

  always_comb begin
    state_n            = state;
    tout_hit           = 1'b0;
    ram_data_address   = cpu_data_address;
    ram_data_read      = cpu_data_read;
    ram_data_write     = cpu_data_write;
    ram_data_writedata = cpu_data_writedata;
    unique case (state)
      WAIT_ACT: begin
        if (cyc == MAXC) begin
          state_n  = DONE;
          tout_hit = 1'b1;
        end else if (cpu_active) begin
          state_n = RUN;
        end
      end
      RUN: begin
        // A halt on the same edge as the deadline still counts as a halt
        if (!cpu_active) begin
          state_n = (WORD_COUNT == 0) ? DONE : SCAN;
        end else if (cyc == MAXC) begin
          state_n  = DONE;
          tout_hit = 1'b1;
        end
      end
      SCAN: begin
        ram_data_address   = BASE_ADDR + (idx << 2);
        ram_data_read      = 1'b1;
        ram_data_write     = 1'b0;
        ram_data_writedata = '0;
        if (idx == LAST) state_n = DONE;
      end
      DONE: begin
        ram_data_address   = BASE_ADDR;
        ram_data_read      = 1'b0;
        ram_data_write     = 1'b0;
        ram_data_writedata = '0;
      end
      default: state_n = WAIT_ACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= WAIT_ACT;
      idx     <= '0;
      exp_val <= EXP_INIT;
      cyc     <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == WAIT_ACT || state == RUN)
        cyc <= cyc + 32'd1;
      if (state == SCAN) begin
        idx     <= idx + 32'd1;
        exp_val <= exp_val + EXP_STEP;
        err_q   <= err_n;
      end
      if (tout_hit) tout_q <= 1'b1;
      // Verdict includes the compare made on the final scan edge
      if (state != DONE && state_n == DONE)
        pass_q <= (state == SCAN) ? (err_n == 16'd0) : !tout_hit;
    end
  end

`ifdef RESULT_SCAN_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_valid <= 1'b0;
    end else if (state == SCAN && mism && !fail_valid) begin
      fail_addr  <= ram_data_address;
      fail_data  <= ram_data_readdata;
      fail_valid <= 1'b1;
    end
  end
`endif

endmodule
